// File: rtl/wb_unit_pkg.sv
// Shared writeback-stage types: write-data select, load size and FSM state encodings.
package wb_unit_pkg;

  typedef enum logic [1:0] {
    WB_PC  = 2'b00,
    WB_CSR = 2'b01,
    WB_MEM = 2'b10,
    WB_ALU = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_B = 2'b00,
    LD_H = 2'b01,
    LD_W = 2'b10
  } ld_size_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_MEM = 2'b01,
    DRAIN    = 2'b10
  } wb_state_e;

  // Load attributes held while the memory response is outstanding.
  typedef struct packed {
    logic [1:0] size;
    logic       uns;
    logic [1:0] addr_lo;
    logic       we;
  } ld_ctl_t;

endpackage

// File: rtl/wb_unit_load_align.sv
// Combinational load extraction: shifts the addressed byte/half down and sign/zero-extends it.
module wb_unit_load_align
  import wb_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      size_i,
  input  logic            uns_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o
);

  logic [4:0]      sh;
  logic [XLEN-1:0] v;

  always_comb begin
    sh = 5'd0;
    unique case (size_i)
      LD_B:    sh = {addr_lo_i, 3'b000};
      LD_H:    sh = {addr_lo_i[1], 4'b0000};
      default: sh = 5'd0;
    endcase
  end

  assign v = rdata_i >> sh;

  always_comb begin
    data_o = v;
    unique case (size_i)
      LD_B:    data_o = {{(XLEN-8){v[7] & ~uns_i}}, v[7:0]};
      LD_H:    data_o = {{(XLEN-16){v[15] & ~uns_i}}, v[15:0]};
      default: data_o = v;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Register-file writeback unit: result select, variable-latency load wait with timeout,
// flush handling and sticky error flags.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RADDR_W     = 5,
  parameter int unsigned PC_INC      = 4,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [XLEN-1:0]    in_pc_i,
  input  logic [XLEN-1:0]    in_alu_res_i,
  input  logic [XLEN-1:0]    in_csr_rd_i,
  input  logic [1:0]         in_sel_i,
  input  logic               in_rf_we_i,
  input  logic [RADDR_W-1:0] in_rd_i,
  input  logic [1:0]         in_ld_size_i,
  input  logic               in_ld_uns_i,
  input  logic [1:0]         in_addr_lo_i,
  input  logic               flush_i,
  input  logic               mem_rvalid_i,
  input  logic [XLEN-1:0]    mem_rdata_i,
  output logic               rf_we_o,
  output logic [RADDR_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]    rf_wdata_o,
  output logic               err_timeout_o,
  output logic               err_spurious_o
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  wb_state_e          state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  ld_ctl_t            ld_q, ld_d;
  logic [RADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic               rf_we_q, rf_we_d;
  logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;
  logic               err_to_q, err_to_d;
  logic               err_sp_q, err_sp_d;

  logic               accept;
  logic               is_load;
  logic [XLEN-1:0]    mux_data;
  logic [XLEN-1:0]    ld_data;

  wb_unit_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .rdata_i   (mem_rdata_i),
    .size_i    (ld_q.size),
    .uns_i     (ld_q.uns),
    .addr_lo_i (ld_q.addr_lo),
    .data_o    (ld_data)
  );

  // rst_ni gating keeps in_ready low for the whole reset assertion, not only after the edge.
  assign in_ready_o = rst_ni & ((state_q == IDLE) |
                                ((state_q == WAIT_MEM) & mem_rvalid_i & ~flush_i));
  assign accept     = in_valid_i & in_ready_o & ~flush_i;
  assign is_load    = (wb_sel_e'(in_sel_i) == WB_MEM);

  always_comb begin
    mux_data = in_alu_res_i;
    unique case (wb_sel_e'(in_sel_i))
      WB_PC:   mux_data = in_pc_i + XLEN'(PC_INC);
      WB_CSR:  mux_data = in_csr_rd_i;
      default: mux_data = in_alu_res_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_d       = ld_q;
    ld_rd_d    = ld_rd_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    err_to_d   = err_to_q;
    err_sp_d   = err_sp_q;

    unique case (state_q)
      IDLE: begin
        if (mem_rvalid_i) err_sp_d = 1'b1;
        if (accept) begin
          if (is_load) begin
            ld_d    = '{size: in_ld_size_i, uns: in_ld_uns_i, addr_lo: in_addr_lo_i,
                        we: in_rf_we_i};
            ld_rd_d = in_rd_i;
            cnt_d   = '0;
            state_d = WAIT_MEM;
          end else begin
            rf_we_d    = in_rf_we_i & (in_rd_i != '0);
            rf_waddr_d = in_rd_i;
            rf_wdata_d = mux_data;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
          if (!flush_i) begin
            rf_we_d    = ld_q.we & (ld_rd_q != '0);
            rf_waddr_d = ld_rd_q;
            rf_wdata_d = ld_data;
            if (accept) begin
              if (is_load) begin
                ld_d    = '{size: in_ld_size_i, uns: in_ld_uns_i, addr_lo: in_addr_lo_i,
                            we: in_rf_we_i};
                ld_rd_d = in_rd_i;
                cnt_d   = '0;
                state_d = WAIT_MEM;
              end else begin
                // Write port already taken by the load; the non-load is dropped.
                err_sp_d = 1'b1;
              end
            end
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntW'(MEM_TIMEOUT)) begin
            err_to_d = 1'b1;
            state_d  = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ld_q       <= '0;
      ld_rd_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_to_q   <= 1'b0;
      err_sp_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_q       <= ld_d;
      ld_rd_q    <= ld_rd_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_to_q   <= err_to_d;
      err_sp_q   <= err_sp_d;
    end
  end

  assign rf_we_o        = rf_we_q;
  assign rf_waddr_o     = rf_waddr_q;
  assign rf_wdata_o     = rf_wdata_q;
  assign err_timeout_o  = err_to_q;
  assign err_spurious_o = err_sp_q;

endmodule

// File: tb/tb_wb_unit.sv
// Directed and randomized checks of wb_unit against arithmetic expectations for each instruction.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_alu, in_csr;
  logic [1:0]  in_sel;
  logic        in_rf_we;
  logic [4:0]  in_rd;
  logic [1:0]  in_ld_size;
  logic        in_ld_uns;
  logic [1:0]  in_addr_lo;
  logic        flush, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        err_timeout, err_spurious;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_unit #(
    .XLEN        (32),
    .RADDR_W     (5),
    .PC_INC      (4),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_pc_i        (in_pc),
    .in_alu_res_i   (in_alu),
    .in_csr_rd_i    (in_csr),
    .in_sel_i       (in_sel),
    .in_rf_we_i     (in_rf_we),
    .in_rd_i        (in_rd),
    .in_ld_size_i   (in_ld_size),
    .in_ld_uns_i    (in_ld_uns),
    .in_addr_lo_i   (in_addr_lo),
    .flush_i        (flush),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata),
    .rf_we_o        (rf_we),
    .rf_waddr_o     (rf_waddr),
    .rf_wdata_o     (rf_wdata),
    .err_timeout_o  (err_timeout),
    .err_spurious_o (err_spurious)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_pc = 0; in_alu = 0; in_csr = 0; in_sel = 0; in_rf_we = 0; in_rd = 0;
    in_ld_size = 0; in_ld_uns = 0; in_addr_lo = 0; flush = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic we);
    in_valid = 1; in_sel = sel; in_rd = rd; in_rf_we = we;
  endtask

  // Reference load value from the addressing rules, using plain arithmetic.
  function automatic logic [31:0] exp_load(input logic [31:0] d, input int sz, input bit uns,
                                           input int a);
    longint unsigned b;
    if (sz == 0) begin
      b = (longint'(d) >> (8 * a)) % 256;
      if (!uns && b >= 128) b = b + 64'hFFFF_FF00;
    end else if (sz == 1) begin
      b = (longint'(d) >> (16 * (a / 2))) % 65536;
      if (!uns && b >= 32768) b = b + 64'hFFFF_0000;
    end else begin
      b = longint'(d);
    end
    return b[31:0];
  endfunction

  initial begin
    idle_inputs();
    rst_n = 0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_errs", {err_timeout, err_spurious}, 0);
    #10 rst_n = 1;
    step();

    // ALU result, one-cycle latency
    chk("idle_ready", in_ready, 1);
    issue(2'b11, 5'd5, 1); in_alu = 32'hDEADBEEF;
    step(); idle_inputs();
    chk("alu_we", rf_we, 1);
    chk("alu_waddr", rf_waddr, 5);
    chk("alu_wdata", rf_wdata, 32'hDEADBEEF);
    step();
    chk("alu_we_pulse", rf_we, 0);

    // Link wraps; rd=0 suppresses write
    issue(2'b00, 5'd7, 1); in_pc = 32'hFFFF_FFFC;
    step();
    chk("link_we", rf_we, 1);
    chk("link_wdata", rf_wdata, 0);
    in_rd = 0;
    step(); idle_inputs();
    chk("x0_we", rf_we, 0);
    issue(2'b01, 5'd3, 1); in_csr = 32'h1234_5678;
    step(); idle_inputs();
    chk("csr_wdata", rf_wdata, 32'h1234_5678);

    // Signed byte load, response 3 cycles after accept
    issue(2'b10, 5'd9, 1); in_ld_size = 0; in_addr_lo = 3; in_ld_uns = 0;
    step(); idle_inputs();
    chk("ld_ready_wait", in_ready, 0);
    step(); step();
    chk("ld_ready_wait2", in_ready, 0);
    chk("ld_no_early_we", rf_we, 0);
    mem_rvalid = 1; mem_rdata = 32'h8011_2233;
    step(); idle_inputs();
    chk("ldb_we", rf_we, 1);
    chk("ldb_waddr", rf_waddr, 9);
    chk("ldb_wdata", rf_wdata, 32'hFFFF_FF80);

    // Back-to-back loads: second accepted in the first response cycle
    issue(2'b10, 5'd10, 1); in_ld_size = 2;
    step(); idle_inputs();
    step();
    mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    issue(2'b10, 5'd11, 1); in_ld_size = 1; in_ld_uns = 1; in_addr_lo = 2;
    #1 chk("b2b_ready", in_ready, 1);
    step(); idle_inputs();
    chk("b2b_1_waddr", rf_waddr, 10);
    chk("b2b_1_wdata", rf_wdata, 32'h1234_5678);
    step();
    chk("b2b_gap_we", rf_we, 0);
    mem_rvalid = 1; mem_rdata = 32'hABCD_0000;
    step(); idle_inputs();
    chk("b2b_2_we", rf_we, 1);
    chk("b2b_2_waddr", rf_waddr, 11);
    chk("b2b_2_wdata", rf_wdata, 32'h0000_ABCD);

    // Flush while waiting, then drain
    issue(2'b10, 5'd12, 1); in_ld_size = 2;
    step(); idle_inputs();
    step();
    flush = 1;
    step(); idle_inputs();
    chk("flush_drain_ready", in_ready, 0);
    mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    step(); idle_inputs();
    chk("flush_no_we", rf_we, 0);
    chk("flush_idle_ready", in_ready, 1);
    chk("flush_errs", {err_timeout, err_spurious}, 0);
    mem_rvalid = 1;
    step(); idle_inputs();
    chk("spurious_idle", err_spurious, 1);
    chk("spurious_no_we", rf_we, 0);

    // Timeout after 4 empty wait cycles
    issue(2'b10, 5'd13, 1); in_ld_size = 2;
    step(); idle_inputs();
    step(); step(); step();
    chk("to_not_yet", err_timeout, 0);
    step();
    chk("to_set", err_timeout, 1);
    chk("to_no_we", rf_we, 0);
    chk("to_drain_ready", in_ready, 0);
    mem_rvalid = 1; mem_rdata = 32'h5555_5555;
    step(); idle_inputs();
    chk("to_late_absorbed", rf_we, 0);
    chk("to_back_idle", in_ready, 1);
    chk("to_sticky", {err_timeout, err_spurious}, 2'b11);

    // Async reset mid-wait
    issue(2'b10, 5'd14, 1); in_ld_size = 2;
    step(); idle_inputs();
    step();
    rst_n = 0;
    #1;
    chk("mid_rst_outs", {rf_we, rf_waddr, err_timeout, err_spurious, in_ready}, 0);
    chk("mid_rst_wdata", rf_wdata, 0);
    #10 rst_n = 1;
    step();
    mem_rvalid = 1;
    step(); idle_inputs();
    chk("post_rst_spurious", err_spurious, 1);
    chk("post_rst_no_we", rf_we, 0);

    // Randomized single-issue traffic
    for (int i = 0; i < 60; i++) begin
      logic [31:0] d, exp_d;
      logic [4:0]  rd;
      logic        we, exp_we;
      int          kind, sz, a, dly;
      bit          uns;
      d = $urandom(); rd = 5'($urandom_range(0, 31)); we = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);
      exp_we = we && (rd != 0);
      if (kind != 2) begin
        in_pc = $urandom(); in_alu = $urandom(); in_csr = $urandom();
        issue(2'(kind), rd, we);
        if (kind == 0) exp_d = in_pc + 32'd4;
        else if (kind == 1) exp_d = in_csr;
        else exp_d = in_alu;
        step(); idle_inputs();
      end else begin
        sz = $urandom_range(0, 3); uns = 1'($urandom_range(0, 1)); a = $urandom_range(0, 3);
        dly = $urandom_range(0, 3);
        issue(2'b10, rd, we); in_ld_size = 2'(sz); in_ld_uns = uns; in_addr_lo = 2'(a);
        step(); idle_inputs();
        repeat (dly) step();
        mem_rvalid = 1; mem_rdata = d;
        exp_d = exp_load(d, sz, uns, a);
        step(); idle_inputs();
      end
      chk("rnd_we", rf_we, exp_we);
      if (exp_we) begin
        chk("rnd_waddr", rf_waddr, rd);
        chk("rnd_wdata", rf_wdata, exp_d);
      end
      step();
    end
    chk("rnd_no_timeout", err_timeout, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
